reg_readback_mem_mp: RTL and testbench
======================================

Name: reg_readback_mem_mp

Overview:
- Parametrised multi-read-port register readback memory for register-file shadowing and CSR readback.
- Generalises the fixed 32-entry, single-port, bit-sliced readback RAM in four ways: configurable width and depth, byte-lane write enables, NRD replicated read ports with optional registered output, and a hardware clear sequencer.
- The clear sequencer initialises all entries to INIT after reset or on request, because distributed RAM cannot be async-reset.

Parameters:
- WID, 16: data width in bits.
- DEPTH, 32: number of entries; power of 2, at least 2.
- AWID, $clog2(DEPTH): address width.
- NRD, 2: number of independent read ports, 1..4.
- RDREG, 1: 1 = registered read with write bypass; 0 = asynchronous read.
- INIT, 0: WID-bit value written to every entry by the clear sweep.
- NLANE, (WID+7)/8: number of byte lanes; the top lane may be partial.

Ports:
- wclk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- wce  in  1  write cycle enable.
- we  in  1  write enable.
- wsel  in  NLANE  byte-lane write select.
- wadr  in  AWID  write address.
- i  in  WID  write data.
- wack  out  1  write accepted this cycle.
- clr  in  1  request a full clear sweep.
- busy  out  1  clear sweep in progress.
- rce  in  NRD  per-port read enable.
- radr  in  NRD*AWID  read addresses; port k uses bits [k*AWID +: AWID].
- o  out  NRD*WID  read data; port k uses bits [k*WID +: WID].
- ovalid  out  NRD  per-port read data valid.

Behaviour:
- Reset: one clock, wclk. Reset is asynchronous and active-low (rst_n).
  - While rst_n=0: state=CLR, cnt=0, busy=1, wack=0, o=0, ovalid=0.
  - Memory contents are undefined until the sweep completes.
- State CLR:
  - Each wclk edge writes INIT to all lanes of entry cnt in every read bank, then cnt<=cnt+1.
  - When cnt==DEPTH-1 the entry is written and the state becomes IDLE on that same edge.
  - The sweep takes exactly DEPTH cycles after rst_n rises; busy falls in cycle DEPTH.
  - User writes are ignored and wack=0. ovalid=0. In RDREG=1 mode o holds its last value.
  - clr asserted during CLR restarts the sweep: cnt<=0.
- State IDLE:
  - wack = wce & we (combinational).
  - On accept, lanes with wsel[l]=1 get i[l] at wadr in all NRD banks; lanes with wsel[l]=0 are unchanged.
  - wsel=0 is accepted (wack=1) but writes nothing.
  - clr=1 moves the state to CLR with cnt=0 next edge. A write in that same cycle is still performed and is later overwritten by the sweep.
- Read, RDREG=1:
  - On an edge with rce[k]=1, o[k] <= mem[radr[k]] and ovalid[k] <= ~busy.
  - Bypass: if the same edge writes radr[k], each selected lane of o[k] takes the new data i; unselected lanes take old data.
  - Latency is 1 cycle.
  - With rce[k]=0, o[k] holds and ovalid[k] <= 0.
- Read, RDREG=0:
  - o[k] = mem[radr[k]] combinationally; ovalid[k] = ~busy; rce is ignored.
  - A write becomes visible after the write edge.
- General rules:
  - Multiple read ports may use the same address; all return identical data.
  - Addresses are exactly AWID bits, so no out-of-range case exists.
  - cnt wraps only through the CLR->IDLE transition and never aliases.
  - Reset asserted mid-sweep or mid-write aborts immediately; the sweep restarts from 0 after rst_n rises.

Decomposition:
- Package reg_readback_pkg holds:
  - state enum {RRB_IDLE, RRB_CLR};
  - the nlane(width) function;
  - the LANE_W=8 constant.
- Sub-module reg_readback_bank: one write port, one async read port, WID x DEPTH distributed RAM with lane enables.
  - Instantiated NRD times, all sharing the write port; each bank serves one read port.
  - The top level holds the FSM, the write/clear mux, bypass logic and output registers.

Test Plan:
- Reset then sweep:
  - Stimulus: INIT=16'hA5A5, DEPTH=32; release rst_n.
  - Required: busy=1 for exactly 32 cycles, then 0. Reading all 32 entries on both ports returns 16'hA5A5 with ovalid=1 one cycle after rce.
- Byte lanes:
  - Stimulus: write 16'h1234 to adr 5 with wsel=2'b11, then 16'hFF00 to adr 5 with wsel=2'b10.
  - Required: read adr 5 returns 16'hFF34.
- Dual-port independence:
  - Stimulus: write adr 3=16'h0003 and adr 7=16'h0007; read port0 adr 3 and port1 adr 7 in the same cycle.
  - Required: next cycle o0=16'h0003, o1=16'h0007, ovalid=2'b11.
- Bypass (RDREG=1):
  - Stimulus: adr 9 holds 16'h1111; in the same cycle write 16'h2222 with wsel=2'b01 to adr 9 and rce[0]=1 with radr0=9.
  - Required: o0=16'h1122.
- clr collision:
  - Stimulus: in IDLE, assert clr together with a write of 16'hBEEF to adr 0.
  - Required: wack=1; busy=1 for 32 cycles; adr 0 then reads INIT. Writes during busy give wack=0 and do not change memory.
- Mid-sweep reset:
  - Stimulus: pull rst_n low at sweep cycle 10.
  - Required: o=0 and ovalid=0 immediately (asynchronously); after rst_n rises, busy stays high for a full 32 cycles.

Source files
------------

// File: rtl/reg_readback_pkg.sv
// Shared types and helpers for the multi-port register readback memory.
// No logic here; used by the bank and the top.
package reg_readback_pkg;

   localparam int LANE_W = 8;

   typedef enum logic [0:0] {
      RRB_IDLE = 1'b0,
      RRB_CLR  = 1'b1
   } rrb_state_t;

   // Number of byte lanes covering a width; the top lane may be partial.
   function automatic int nlane(input int width);
      return (width + LANE_W - 1) / LANE_W;
   endfunction

endpackage

// File: rtl/reg_readback_bank.sv
// One bank: WIDxDEPTH distributed RAM, one lane-masked write port, one async read port.
// Write lands on the wclk edge; read is combinational. No backpressure.
module reg_readback_bank
   import reg_readback_pkg::*;
#(
   parameter int WID   = 16,
   parameter int DEPTH = 32,
   parameter int AWID  = $clog2(DEPTH),
   parameter int NLANE = nlane(WID)
) (
   input  logic             wclk,
   input  logic             we,
   input  logic [NLANE-1:0] wsel,
   input  logic [AWID-1:0]  wadr,
   input  logic [WID-1:0]   wdat,
   input  logic [AWID-1:0]  radr,
   output logic [WID-1:0]   rdat
);

   logic [WID-1:0] mem [DEPTH];
   logic [WID-1:0] wmask;

   always_comb begin
      wmask = '0;
      for (int b = 0; b < WID; b++) begin
         wmask[b] = wsel[b / LANE_W];
      end
   end

   // No reset on the array: contents are initialised by the clear sweep instead.
   always_ff @(posedge wclk) begin
      if (we) begin
         mem[wadr] <= (mem[wadr] & ~wmask) | (wdat & wmask);
      end
   end

   assign rdat = mem[radr];

endmodule

// File: rtl/reg_readback_mem_mp.sv
// Multi-read-port readback memory with byte-lane writes and a clear sweep after reset/clr.
// Read latency 1 (RDREG=1, with write bypass) or 0; writes are refused (wack=0) while busy.
module reg_readback_mem_mp
   import reg_readback_pkg::*;
#(
   parameter int             WID   = 16,
   parameter int             DEPTH = 32,
   parameter int             AWID  = $clog2(DEPTH),
   parameter int             NRD   = 2,
   parameter int             RDREG = 1,
   parameter logic [WID-1:0] INIT  = '0,
   parameter int             NLANE = nlane(WID)
) (
   input  logic                wclk,
   input  logic                rst_n,
   input  logic                wce,
   input  logic                we,
   input  logic [NLANE-1:0]    wsel,
   input  logic [AWID-1:0]     wadr,
   input  logic [WID-1:0]      i,
   output logic                wack,
   input  logic                clr,
   output logic                busy,
   input  logic [NRD-1:0]      rce,
   input  logic [NRD*AWID-1:0] radr,
   output logic [NRD*WID-1:0]  o,
   output logic [NRD-1:0]      ovalid
);

   localparam logic [AWID-1:0] LAST = AWID'(DEPTH - 1);

   rrb_state_t      state;
   logic [AWID-1:0] cnt;

   logic             bk_we;
   logic [NLANE-1:0] bk_wsel;
   logic [AWID-1:0]  bk_wadr;
   logic [WID-1:0]   bk_wdat;
   logic [WID-1:0]   umask;
   logic [WID-1:0]   rdat [NRD];

   assign busy = (state == RRB_CLR);
   assign wack = ~busy & wce & we;

   always_ff @(posedge wclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RRB_CLR;
         cnt   <= '0;
      end else begin
         case (state)
            RRB_CLR: begin
               if (clr) begin
                  cnt <= '0;
               end else if (cnt == LAST) begin
                  state <= RRB_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               if (clr) begin
                  state <= RRB_CLR;
                  cnt   <= '0;
               end
            end
         endcase
      end
   end

   // The sweep owns the shared write port while busy; user writes are dropped.
   always_comb begin
      bk_we   = busy | wack;
      bk_wsel = busy ? '1 : wsel;
      bk_wadr = busy ? cnt : wadr;
      bk_wdat = busy ? INIT : i;
   end

   always_comb begin
      umask = '0;
      for (int b = 0; b < WID; b++) begin
         umask[b] = wsel[b / LANE_W];
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AWID-1:0] ra;

      assign ra = radr[k*AWID +: AWID];

      reg_readback_bank #(
         .WID   (WID),
         .DEPTH (DEPTH),
         .AWID  (AWID),
         .NLANE (NLANE)
      ) u_bank (
         .wclk (wclk),
         .we   (bk_we),
         .wsel (bk_wsel),
         .wadr (bk_wadr),
         .wdat (bk_wdat),
         .radr (ra),
         .rdat (rdat[k])
      );

      if (RDREG != 0) begin : g_reg
         logic           hit;
         logic [WID-1:0] byp;
         logic [WID-1:0] oq;
         logic           ov;

         // Same-edge write to the read address: selected lanes come from i.
         always_comb begin
            hit = wack && (wadr == ra);
            byp = hit ? ((rdat[k] & ~umask) | (i & umask)) : rdat[k];
         end

         always_ff @(posedge wclk or negedge rst_n) begin
            if (!rst_n) begin
               oq <= '0;
               ov <= 1'b0;
            end else begin
               ov <= rce[k] & ~busy;
               if (rce[k] && !busy) begin
                  oq <= byp;
               end
            end
         end

         assign o[k*WID +: WID] = oq;
         assign ovalid[k]       = ov;
      end else begin : g_async
         assign o[k*WID +: WID] = rst_n ? rdat[k] : '0;
         assign ovalid[k]       = rst_n & ~busy;
      end
   end

endmodule

// File: tb/tb_reg_readback_mem_mp.sv
// Directed bench: stimulus pushes expected read data, a negedge monitor pops and compares.
module tb_reg_readback_mem_mp;

   logic        wclk;
   logic        rst_n;
   logic        wce, we;
   logic [1:0]  wsel;
   logic [4:0]  wadr;
   logic [15:0] i;
   logic        wack;
   logic        clr;
   logic        busy;
   logic [1:0]  rce;
   logic [9:0]  radr;
   logic [31:0] o;
   logic [1:0]  ovalid;

   int checks   = 0;
   int failures = 0;

   logic [15:0] q0[$];
   logic [15:0] q1[$];
   logic [15:0] e0, e1;

   reg_readback_mem_mp #(
      .WID   (16),
      .DEPTH (32),
      .NRD   (2),
      .RDREG (1),
      .INIT  (16'hA5A5)
   ) dut (
      .wclk   (wclk),
      .rst_n  (rst_n),
      .wce    (wce),
      .we     (we),
      .wsel   (wsel),
      .wadr   (wadr),
      .i      (i),
      .wack   (wack),
      .clr    (clr),
      .busy   (busy),
      .rce    (rce),
      .radr   (radr),
      .o      (o),
      .ovalid (ovalid)
   );

   initial begin
      wclk = 1'b0;
      forever #5 wclk = ~wclk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor: every valid read beat must match the oldest expectation for that port.
   always @(negedge wclk) begin
      if (rst_n) begin
         if (ovalid[0]) begin
            if (q0.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL port0_unexpected_valid actual=%h required=none", o[15:0]);
            end else begin
               e0 = q0.pop_front();
               chk("port0_rdata", {16'h0, o[15:0]}, {16'h0, e0});
            end
         end
         if (ovalid[1]) begin
            if (q1.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL port1_unexpected_valid actual=%h required=none", o[31:16]);
            end else begin
               e1 = q1.pop_front();
               chk("port1_rdata", {16'h0, o[31:16]}, {16'h0, e1});
            end
         end
      end
   end

   task automatic wr(input logic [4:0] a, input logic [15:0] d, input logic [1:0] s);
      wce = 1'b1; we = 1'b1; wadr = a; i = d; wsel = s;
      #1;
      chk("wack_idle", {31'h0, wack}, 32'h1);
      @(posedge wclk); #1;
      wce = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                     input logic [15:0] x0, input logic [15:0] x1);
      rce  = en;
      radr = {a1, a0};
      if (en[0]) q0.push_back(x0);
      if (en[1]) q1.push_back(x1);
      @(posedge wclk); #1;
      rce = 2'b00;
   endtask

   // Counts busy cycles from the next negedge; also notes any wack seen while busy.
   task automatic count_busy(output int n, output logic sw);
      n  = 0;
      sw = 1'b0;
      @(negedge wclk);
      while (busy && n < 200) begin
         if (wack) sw = 1'b1;
         n++;
         @(negedge wclk);
      end
      wce = 1'b0; we = 1'b0;
      @(posedge wclk); #1;
   endtask

   initial begin
      int   n;
      logic sw;
      rst_n = 1'b0; wce = 1'b1; we = 1'b1; wsel = 2'b11; wadr = '0; i = 16'h5555;
      clr = 1'b0; rce = 2'b11; radr = '0;
      #23;
      chk("reset_busy",   {31'h0, busy},   32'h1);
      chk("reset_wack",   {31'h0, wack},   32'h0);
      chk("reset_o",      o,               32'h0);
      chk("reset_ovalid", {30'h0, ovalid}, 32'h0);
      wce = 1'b0; we = 1'b0; rce = 2'b00;

      @(posedge wclk); #1;
      rst_n = 1'b1;
      count_busy(n, sw);
      chk("sweep_busy_cycles", n, 32);

      for (int a = 0; a < 32; a++) begin
         rd(2'b11, 5'(a), 5'(31 - a), 16'hA5A5, 16'hA5A5);
      end

      wr(5'd5, 16'h1234, 2'b11);
      wr(5'd5, 16'hFF00, 2'b10);
      rd(2'b11, 5'd5, 5'd5, 16'hFF34, 16'hFF34);

      wr(5'd3, 16'h0003, 2'b11);
      wr(5'd7, 16'h0007, 2'b11);
      rd(2'b11, 5'd3, 5'd7, 16'h0003, 16'h0007);
      #4;
      chk("dual_ovalid", {30'h0, ovalid}, 32'h3);

      wr(5'd9, 16'h1111, 2'b11);
      wce = 1'b1; we = 1'b1; wadr = 5'd9; i = 16'h2222; wsel = 2'b01;
      rce = 2'b11; radr = {5'd9, 5'd9};
      q0.push_back(16'h1122);
      q1.push_back(16'h1122);
      #1;
      chk("wack_bypass", {31'h0, wack}, 32'h1);
      @(posedge wclk); #1;
      wce = 1'b0; we = 1'b0; rce = 2'b00;

      wr(5'd9, 16'hFFFF, 2'b00);
      rd(2'b11, 5'd9, 5'd9, 16'h1122, 16'h1122);

      clr = 1'b1; wce = 1'b1; we = 1'b1; wadr = 5'd0; i = 16'hBEEF; wsel = 2'b11;
      #1;
      chk("clr_collision_wack", {31'h0, wack}, 32'h1);
      @(posedge wclk); #1;
      clr = 1'b0; i = 16'hDEAD;
      count_busy(n, sw);
      chk("clr_busy_cycles", n, 32);
      chk("busy_wack_low", {31'h0, sw}, 32'h0);
      rd(2'b11, 5'd0, 5'd5, 16'hA5A5, 16'hA5A5);

      clr = 1'b1;
      @(posedge wclk); #1;
      clr = 1'b0;
      repeat (10) @(posedge wclk);
      #1;
      chk("clr_o_hold", o, 32'hA5A5_A5A5);
      rst_n = 1'b0;
      #1;
      chk("midsweep_o",      o,               32'h0);
      chk("midsweep_ovalid", {30'h0, ovalid}, 32'h0);
      chk("midsweep_busy",   {31'h0, busy},   32'h1);
      repeat (3) @(posedge wclk);
      #1;
      rst_n = 1'b1;
      count_busy(n, sw);
      chk("restart_busy_cycles", n, 32);
      rd(2'b11, 5'd9, 5'd3, 16'hA5A5, 16'hA5A5);

      repeat (3) @(posedge wclk);
      #1;
      chk("port0_pending", q0.size(), 0);
      chk("port1_pending", q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
